// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port data memory slave on the req/gnt/rvalid bus.
// Byte-enabled writes, registered read data, optional grant wait states.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int GNT_WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic        stall_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int WW =
    (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
  localparam logic [WW-1:0] WMAX = WW'(GNT_WAIT);

  logic [WW-1:0]         wcnt;
  logic [31:0]           mem [DEPTH];
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;

  assign in_range = (data_addr_i[31:ADDR_WIDTH] == '0);
  assign idx      = data_addr_i[ADDR_WIDTH-1:0];

  assign data_gnt_o = rst_n & data_req_i & ~stall_i
                    & (wcnt == WMAX);

  // Stall holds the count so a saturated request grants as soon as it lifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (!data_req_i || data_gnt_o) begin
      wcnt <= '0;
    end else if (wcnt != WMAX) begin
      wcnt <= wcnt + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (data_gnt_o && data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else if (data_gnt_o) begin
      data_rvalid_o <= 1'b1;
      data_err_o    <= ~in_range;
      data_rdata_o  <= (in_range && !data_we_i) ?
                       mem[idx] : '0;
    end else begin
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of data_mem_responder
// with zero and two grant wait states.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req0, req2;
  logic        stall0, stall2;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        gnt0, rv0, err0;
  logic [31:0] rd0;
  logic        gnt2, rv2, err2;
  logic [31:0] rd2;

  int nvec = 0;
  int nerr = 0;

  data_mem_responder #(.ADDR_WIDTH(10), .GNT_WAIT(0)) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_req_i    (req0),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .stall_i       (stall0),
    .data_gnt_o    (gnt0),
    .data_rvalid_o (rv0),
    .data_rdata_o  (rd0),
    .data_err_o    (err0)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .GNT_WAIT(2)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_req_i    (req2),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .stall_i       (stall2),
    .data_gnt_o    (gnt2),
    .data_rvalid_o (rv2),
    .data_rdata_o  (rd2),
    .data_err_o    (err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic r2,
                     input logic s2, input logic w,
                     input logic [31:0] a,
                     input logic [3:0] b,
                     input logic [31:0] d);
    @(negedge clk);
    req0 = r0; req2 = r2; stall2 = s2;
    we = w; addr = a; be = b; wdata = d;
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req2 = 1'b1;
    stall0 = 1'b0; stall2 = 1'b0;
    we = 1'b0; addr = '0; be = '0; wdata = '0;
    #3;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt2", 32'(gnt2), 32'd0);
    chk("rst_rv0", 32'(rv0), 32'd0);
    chk("rst_rd0", rd0, 32'h0);
    idle();
    rst_n = 1'b1;
    idle();

    // word write then read
    drv(1, 0, 0, 1, 32'h5, 4'hF, 32'hDEADBEEF);
    chk("wr5_gnt", 32'(gnt0), 32'd1);
    drv(1, 0, 0, 0, 32'h5, 4'hF, 32'h0);
    chk("wr5_rv", 32'(rv0), 32'd1);
    chk("wr5_rd", rd0, 32'h0);
    chk("wr5_err", 32'(err0), 32'd0);
    chk("rd5_gnt", 32'(gnt0), 32'd1);
    idle();
    chk("rd5_rv", 32'(rv0), 32'd1);
    chk("rd5_rd", rd0, 32'hDEADBEEF);
    chk("rd5_err", 32'(err0), 32'd0);
    idle();
    chk("idle_rv", 32'(rv0), 32'd0);
    chk("idle_hold", rd0, 32'hDEADBEEF);

    // byte lanes, be=0000 write, be ignored on read
    drv(1, 0, 0, 1, 32'h3, 4'hF, 32'h00000000);
    drv(1, 0, 0, 1, 32'h3, 4'b0100, 32'hFFABFFFF);
    drv(1, 0, 0, 1, 32'h3, 4'b0011, 32'hFFFF1234);
    drv(1, 0, 0, 1, 32'h3, 4'b0000, 32'hFFFFFFFF);
    drv(1, 0, 0, 0, 32'h3, 4'b0000, 32'h0);
    idle();
    chk("lane_rd", rd0, 32'h00AB1234);
    chk("lane_rv", 32'(rv0), 32'd1);

    // back-to-back write then read, same address
    drv(1, 0, 0, 1, 32'h7, 4'hF, 32'h11111111);
    chk("b2b_gnt1", 32'(gnt0), 32'd1);
    drv(1, 0, 0, 0, 32'h7, 4'hF, 32'h0);
    chk("b2b_gnt2", 32'(gnt0), 32'd1);
    chk("b2b_rv1", 32'(rv0), 32'd1);
    chk("b2b_rd1", rd0, 32'h0);
    idle();
    chk("b2b_rv2", 32'(rv0), 32'd1);
    chk("b2b_rd2", rd0, 32'h11111111);

    // out of range
    drv(1, 0, 0, 1, 32'h0, 4'hF, 32'h12345678);
    drv(1, 0, 0, 1, 32'h400, 4'hF, 32'hCAFEF00D);
    chk("oor_gnt", 32'(gnt0), 32'd1);
    drv(1, 0, 0, 0, 32'h400, 4'hF, 32'h0);
    chk("oorw_rv", 32'(rv0), 32'd1);
    chk("oorw_err", 32'(err0), 32'd1);
    chk("oorw_rd", rd0, 32'h0);
    drv(1, 0, 0, 0, 32'h0, 4'hF, 32'h0);
    chk("oorr_rd", rd0, 32'h0);
    chk("oorr_err", 32'(err0), 32'd1);
    idle();
    chk("a0_rd", rd0, 32'h12345678);
    chk("a0_err", 32'(err0), 32'd0);
    idle();
    chk("oor_rv_off", 32'(rv0), 32'd0);
    chk("oor_err_off", 32'(err0), 32'd0);

    // two wait states; addr changes before grant are ignored
    drv(0, 1, 0, 1, 32'h20, 4'hF, 32'h0BADBEEF);
    chk("w2_c1", 32'(gnt2), 32'd0);
    drv(0, 1, 0, 1, 32'h21, 4'hF, 32'h0BADBEEF);
    chk("w2_c2", 32'(gnt2), 32'd0);
    chk("w2_norv", 32'(rv2), 32'd0);
    drv(0, 1, 0, 1, 32'h9, 4'hF, 32'hA5A5A5A5);
    chk("w2_c3", 32'(gnt2), 32'd1);
    idle();
    chk("w2_rv", 32'(rv2), 32'd1);
    chk("w2_rd", rd2, 32'h0);
    chk("w2_err", 32'(err2), 32'd0);
    idle();
    chk("w2_rv_off", 32'(rv2), 32'd0);

    // stall delays grant past saturation
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 1, 0, 32'h9, 4'h0, 32'h0);
      chk("st_gnt0", 32'(gnt2), 32'd0);
    end
    chk("st_norv", 32'(rv2), 32'd0);
    drv(0, 1, 0, 0, 32'h9, 4'h0, 32'h0);
    chk("st_gnt1", 32'(gnt2), 32'd1);
    idle();
    chk("st_rv", 32'(rv2), 32'd1);
    chk("st_rd", rd2, 32'hA5A5A5A5);
    idle();
    chk("st_one", 32'(rv2), 32'd0);

    // request dropped before grant clears the count
    drv(0, 1, 0, 0, 32'h9, 4'h0, 32'h0);
    chk("dr_gnt", 32'(gnt2), 32'd0);
    idle();
    chk("dr_norv", 32'(rv2), 32'd0);
    drv(0, 1, 0, 0, 32'h9, 4'h0, 32'h0);
    chk("dr_c1", 32'(gnt2), 32'd0);
    drv(0, 1, 0, 0, 32'h9, 4'h0, 32'h0);
    chk("dr_c2", 32'(gnt2), 32'd0);
    drv(0, 1, 0, 0, 32'h9, 4'h0, 32'h0);
    chk("dr_c3", 32'(gnt2), 32'd1);
    idle();
    chk("dr_rd", rd2, 32'hA5A5A5A5);

    // asynchronous reset during a read response
    drv(1, 0, 0, 0, 32'h5, 4'hF, 32'h0);
    chk("rr_gnt", 32'(gnt0), 32'd1);
    drv(1, 0, 0, 0, 32'h5, 4'hF, 32'h0);
    chk("rr_rv", 32'(rv0), 32'd1);
    chk("rr_rd", rd0, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rv", 32'(rv0), 32'd0);
    chk("ar_rd", rd0, 32'h0);
    chk("ar_err", 32'(err0), 32'd0);
    chk("ar_gnt", 32'(gnt0), 32'd0);
    idle();
    rst_n = 1'b1;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
